// File: rtl/ifc_pkg.sv
// Shared types for the n-ary operator block: operation codes and FSM states.
package ifc_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_COMPUTE = 1'b1
  } state_t;

  // Headroom for summing up to 8 operands without losing the carry-out.
  localparam int CARRY_BITS = 3;

endpackage

// File: rtl/ifc_result_fifo.sv
// Two-entry first-in first-out result buffer with registered storage.
module ifc_result_fifo
  import ifc_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_r [2];
  logic         rd_ptr_r;
  logic         wr_ptr_r;
  logic [1:0]   count_r;
  logic         do_pop_s;

  assign do_pop_s = pop & ~empty;

  // Storage, pointers and occupancy; a push while full is only issued alongside a pop.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mem_r[0] <= {W{1'b0}};
      mem_r[1] <= {W{1'b0}};
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = (count_r == 2'd2);
  assign empty = (count_r == 2'd0);

endmodule

// File: rtl/ifc_nary_op.sv
// Collects NUM_IN operands over independent handshakes, reduces them with the
// selected operation and queues {carry, result} in a two-entry buffer.
module ifc_nary_op
  import ifc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_en,
  output logic [NUM_IN-1:0]       in_rdy,
  input  logic [1:0]              op_sel,
  output logic [WIDTH-1:0]        y_data,
  output logic                    y_carry,
  output logic                    y_rdy,
  input  logic                    y_en
);

  localparam int SUM_W = WIDTH + CARRY_BITS;

  state_t            state_r;
  op_t               op_r;
  logic [NUM_IN-1:0] captured_r;
  logic [WIDTH-1:0]  opnd_r [NUM_IN];

  logic [NUM_IN-1:0] cap_s;
  logic              all_in_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [WIDTH-1:0]  acc_s;
  logic [SUM_W-1:0]  sum_s;
  logic [WIDTH:0]    result_s;
  logic [WIDTH:0]    head_s;

  // Ready is forced low while reset is asserted so nothing is accepted in that cycle.
  always_comb begin
    if (!RST_N) begin
      in_rdy = {NUM_IN{1'b0}};
    end else if (state_r == ST_COLLECT) begin
      in_rdy = ~captured_r;
    end else begin
      in_rdy = {NUM_IN{1'b0}};
    end
  end

  assign cap_s    = in_en & in_rdy;
  assign all_in_s = &(captured_r | cap_s);
  assign pop_s    = y_en & y_rdy;
  assign push_s   = (state_r == ST_COMPUTE) & (~full_s | pop_s);

  // Reduce the held operands; ADD keeps extra high bits so the carry survives.
  always_comb begin
    acc_s = (op_r == OP_AND) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    sum_s = {SUM_W{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      case (op_r)
        OP_OR:   acc_s = acc_s | opnd_r[i];
        OP_AND:  acc_s = acc_s & opnd_r[i];
        OP_XOR:  acc_s = acc_s ^ opnd_r[i];
        OP_ADD:  sum_s = sum_s + SUM_W'(opnd_r[i]);
        default: acc_s = acc_s;
      endcase
    end
    if (op_r == OP_ADD) begin
      result_s = {|sum_s[SUM_W-1:WIDTH], sum_s[WIDTH-1:0]};
    end else begin
      result_s = {1'b0, acc_s};
    end
  end

  // Collect/compute sequencing; operands stay frozen in COMPUTE until the push.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r    <= ST_COLLECT;
      op_r       <= OP_OR;
      captured_r <= {NUM_IN{1'b0}};
      for (int i = 0; i < NUM_IN; i++) begin
        opnd_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      case (state_r)
        ST_COLLECT: begin
          for (int i = 0; i < NUM_IN; i++) begin
            if (cap_s[i]) begin
              opnd_r[i] <= in_data[i*WIDTH +: WIDTH];
            end
          end
          if (cap_s[0]) begin
            op_r <= op_t'(op_sel);
          end
          captured_r <= captured_r | cap_s;
          if (all_in_s) begin
            state_r <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (push_s) begin
            captured_r <= {NUM_IN{1'b0}};
            state_r    <= ST_COLLECT;
          end
        end
        default: state_r <= ST_COLLECT;
      endcase
    end
  end

  ifc_result_fifo #(
    .W(WIDTH + 1)
  ) u_fifo (
    .CLK  (CLK),
    .RST_N(RST_N),
    .push (push_s),
    .pop  (pop_s),
    .din  (result_s),
    .dout (head_s),
    .full (full_s),
    .empty(empty_s)
  );

  assign y_data  = head_s[WIDTH-1:0];
  assign y_carry = head_s[WIDTH];
  assign y_rdy   = ~empty_s;

endmodule

// File: tb/tb_ifc_nary_op.sv
// Scoreboard bench: expected results are queued at issue time and compared by monitors.
module tb_ifc_nary_op;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  // Two-channel instance
  logic [15:0] a_in_data;
  logic [1:0]  a_in_en, a_in_rdy, a_op_sel;
  logic [7:0]  a_y_data;
  logic        a_y_carry, a_y_rdy, a_y_en;
  // Three-channel instance
  logic [23:0] b_in_data;
  logic [2:0]  b_in_en, b_in_rdy;
  logic [1:0]  b_op_sel;
  logic [7:0]  b_y_data;
  logic        b_y_carry, b_y_rdy, b_y_en;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_a_q[$];
  logic [8:0] exp_b_q[$];
  bit rand_a = 1'b0;

  ifc_nary_op #(.WIDTH(8), .NUM_IN(2)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .in_data(a_in_data), .in_en(a_in_en), .in_rdy(a_in_rdy),
    .op_sel(a_op_sel), .y_data(a_y_data), .y_carry(a_y_carry), .y_rdy(a_y_rdy), .y_en(a_y_en)
  );

  ifc_nary_op #(.WIDTH(8), .NUM_IN(3)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .in_data(b_in_data), .in_en(b_in_en), .in_rdy(b_in_rdy),
    .op_sel(b_op_sel), .y_data(b_y_data), .y_carry(b_y_carry), .y_rdy(b_y_rdy), .y_en(b_y_en)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: reduce a list of operands by the named operation, carry = true sum overflow.
  function automatic logic [8:0] model(input logic [1:0] op, input int unsigned v[8], input int n);
    int unsigned r;
    r = (op == 2'b01) ? 32'd255 : 32'd0;
    for (int i = 0; i < n; i++) begin
      case (op)
        2'b00:   r = r | v[i];
        2'b01:   r = r & v[i];
        2'b10:   r = r ^ v[i];
        default: r = r + v[i];
      endcase
    end
    model = {(op == 2'b11) && (r >= 32'd256), r[7:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (rand_a) a_y_en = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rdy_a();
    int n = 0;
    while (a_in_rdy != 2'b11 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("a_rdy_timeout", {30'd0, a_in_rdy}, 32'h3);
  endtask

  // order: 0 = both together, 1 = ch1 then ch0, 2 = ch0 then ch1
  task automatic issue_a(input logic [1:0] op, input logic [7:0] v0, input logic [7:0] v1, input int order);
    int unsigned v[8];
    v = '{default: 0};
    v[0] = v0;
    v[1] = v1;
    wait_rdy_a();
    exp_a_q.push_back(model(op, v, 2));
    a_in_data = {v1, v0};
    a_op_sel = op;
    if (order == 0) begin
      a_in_en = 2'b11; tick(); a_in_en = 2'b00;
    end else if (order == 1) begin
      a_in_en = 2'b10; tick(); a_in_en = 2'b00;
      check("a_rdy_after_ch1", {30'd0, a_in_rdy}, 32'h1);
      a_in_en = 2'b01; tick(); a_in_en = 2'b00;
      check("a_rdy_after_ch0", {30'd0, a_in_rdy}, 32'h0);
    end else begin
      a_in_en = 2'b01; tick(); a_in_en = 2'b00;
      check("a_rdy_after_first_ch0", {30'd0, a_in_rdy}, 32'h2);
      a_in_en = 2'b10; tick(); a_in_en = 2'b00;
    end
  endtask

  task automatic drain_a();
    int n = 0;
    rand_a = 1'b0;
    a_y_en = 1'b1;
    while (exp_a_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    a_y_en = 1'b0;
    check("a_drain_left", exp_a_q.size(), 32'd0);
  endtask

  task automatic issue_b(input logic [1:0] op, input logic [7:0] v0, input logic [7:0] v1, input logic [7:0] v2);
    int unsigned v[8];
    int n = 0;
    v = '{default: 0};
    v[0] = v0; v[1] = v1; v[2] = v2;
    while (b_in_rdy != 3'b111 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("b_rdy_timeout", {29'd0, b_in_rdy}, 32'h7);
    exp_b_q.push_back(model(op, v, 3));
    b_in_data = {v2, v1, v0};
    b_op_sel = op;
    b_in_en = 3'b111; tick(); b_in_en = 3'b000;
  endtask

  task automatic drain_b();
    int n = 0;
    while (exp_b_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("b_drain_left", exp_b_q.size(), 32'd0);
  endtask

  // Monitor for the two-channel instance: every accepted pop is checked against the queue head.
  always @(negedge CLK) begin
    logic [8:0] e;
    if (RST_N && a_y_rdy && a_y_en) begin
      if (exp_a_q.size() == 0) begin
        check("a_unexpected_result", {31'd0, a_y_rdy}, 32'd0);
      end else begin
        e = exp_a_q.pop_front();
        check("a_y_data", {24'd0, a_y_data}, {24'd0, e[7:0]});
        check("a_y_carry", {31'd0, a_y_carry}, {31'd0, e[8]});
      end
    end
  end

  // Monitor for the three-channel instance.
  always @(negedge CLK) begin
    logic [8:0] e;
    if (RST_N && b_y_rdy && b_y_en) begin
      if (exp_b_q.size() == 0) begin
        check("b_unexpected_result", {31'd0, b_y_rdy}, 32'd0);
      end else begin
        e = exp_b_q.pop_front();
        check("b_y_data", {24'd0, b_y_data}, {24'd0, e[7:0]});
        check("b_y_carry", {31'd0, b_y_carry}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    a_in_data = 16'd0; a_in_en = 2'b00; a_op_sel = 2'b00; a_y_en = 1'b0;
    b_in_data = 24'd0; b_in_en = 3'b000; b_op_sel = 2'b00; b_y_en = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("rst_in_rdy_low", {30'd0, a_in_rdy}, 32'h0);
    check("rst_y_rdy", {31'd0, a_y_rdy}, 32'h0);
    check("rst_y_data", {24'd0, a_y_data}, 32'h0);
    check("rst_y_carry", {31'd0, a_y_carry}, 32'h0);
    RST_N = 1'b1;
    #1;
    check("post_rst_in_rdy", {30'd0, a_in_rdy}, 32'h3);
    check("post_rst_b_in_rdy", {29'd0, b_in_rdy}, 32'h7);
    tick();

    // OR with latency check: result visible exactly one edge after the last capture
    issue_a(2'b00, 8'h0F, 8'hF0, 2);
    check("lat_y_rdy_k", {31'd0, a_y_rdy}, 32'h0);
    tick();
    check("lat_y_rdy_k1", {31'd0, a_y_rdy}, 32'h1);
    drain_a();

    // AND with ch1 captured first
    issue_a(2'b01, 8'hAA, 8'h0F, 1);
    drain_a();

    // Three ops with no pops: buffer fills, third stalls in COMPUTE
    issue_a(2'b11, 8'h10, 8'h20, 0);
    issue_a(2'b10, 8'h3C, 8'h0F, 0);
    issue_a(2'b11, 8'h80, 8'h80, 0);
    tick(); tick();
    check("stall_in_rdy", {30'd0, a_in_rdy}, 32'h0);
    check("stall_y_rdy", {31'd0, a_y_rdy}, 32'h1);
    a_y_en = 1'b1;
    tick();
    a_y_en = 1'b0;
    check("unstall_in_rdy", {30'd0, a_in_rdy}, 32'h3);
    check("unstall_y_rdy", {31'd0, a_y_rdy}, 32'h1);
    drain_a();

    // Reset mid-operation with one buffered result and ch0 captured
    issue_a(2'b00, 8'h11, 8'h22, 0);
    wait_rdy_a();
    a_in_data = 16'h0033; a_op_sel = 2'b11; a_in_en = 2'b01;
    tick();
    a_in_en = 2'b00;
    check("pre_rst_y_rdy", {31'd0, a_y_rdy}, 32'h1);
    RST_N = 1'b0;
    #1;
    check("mid_rst_in_rdy", {30'd0, a_in_rdy}, 32'h0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
    #1;
    check("mid_rst_y_rdy", {31'd0, a_y_rdy}, 32'h0);
    check("mid_rst_y_data", {24'd0, a_y_data}, 32'h0);
    check("mid_rst_y_carry", {31'd0, a_y_carry}, 32'h0);
    check("mid_rst_in_rdy_after", {30'd0, a_in_rdy}, 32'h3);
    tick();

    // ADD with overflow, also proves no stale result follows the reset
    issue_a(2'b11, 8'hFF, 8'h02, 0);
    drain_a();

    // Three-channel XOR and a few random ops
    issue_b(2'b10, 8'h01, 8'h02, 8'h04);
    for (int i = 0; i < 6; i++) begin
      issue_b(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    issue_b(2'b11, 8'hFF, 8'hFF, 8'hFF);
    drain_b();

    // Randomized traffic with random back-pressure
    rand_a = 1'b1;
    for (int i = 0; i < 60; i++) begin
      issue_a(2'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end
    drain_a();
    tick(); tick();
    check("final_a_y_rdy", {31'd0, a_y_rdy}, 32'h0);
    check("final_b_y_rdy", {31'd0, b_y_rdy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifc_nary_op.md
IFC_NARY_OP -- requirements
Module: ifc_nary_op

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of every operand and of the result (legal 1..32).
REQ-002 Parameter NUM_IN, default 2, SHALL set the number of operand channels (legal 2..8).
REQ-003 CLK  input  1  SHALL be the clock; every register SHALL update on its rising edge.
REQ-004 RST_N  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_data  input  NUM_IN*WIDTH  SHALL carry the operands; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 in_en  input  NUM_IN  SHALL be the per-channel enable; a capture happens only when both in_en[i] and in_rdy[i] are high.
REQ-007 in_rdy  output  NUM_IN  SHALL be the per-channel ready.
REQ-008 op_sel  input  2  SHALL select the operation; it is sampled only on a channel-0 capture.
REQ-009 y_data  output  WIDTH  SHALL be the result at the head of the result buffer.
REQ-010 y_carry  output  1  SHALL be the ADD overflow flag at the head of the result buffer.
REQ-011 y_rdy  output  1  SHALL indicate that the result buffer is not empty.
REQ-012 y_en  input  1  SHALL pop the buffer head when both y_en and y_rdy are high; y_en while y_rdy is low SHALL be ignored.

Function
REQ-013 The FSM SHALL have exactly two states: COLLECT and COMPUTE.
REQ-014 In COLLECT, in_rdy[i] SHALL equal the inverse of captured flag i; in COMPUTE, every in_rdy bit SHALL be 0.
REQ-015 A channel capture SHALL load that channel's operand register and set its captured flag; in_en[i] while in_rdy[i] is low SHALL be ignored.
REQ-016 Operands SHALL be accepted in any order, several or all of them in the same cycle.
REQ-017 At an edge in COLLECT where every channel is already captured or is being captured, the FSM SHALL enter COMPUTE.
REQ-018 In COMPUTE, the result SHALL be pushed into the buffer if count<2 or a pop happens at the same edge; on a push, all captured flags SHALL clear and the FSM SHALL return to COLLECT.
REQ-019 If the buffer is full and no pop happens, the FSM SHALL stay in COMPUTE holding the operands, with in_rdy=0.
REQ-020 op_sel decoding: 00 = OR, 01 = AND, 10 = XOR, 11 = ADD; each op reduces all NUM_IN operands.
REQ-021 ADD SHALL produce the sum modulo 2^WIDTH, and y_carry=1 if and only if the true sum is >= 2^WIDTH.
REQ-022 For OR, AND and XOR, y_carry SHALL be 0.
REQ-023 Latency: last operand captured at edge k -> result pushed at edge k+1 -> y_rdy=1 after edge k+1 if the buffer was empty.
REQ-024 The result buffer SHALL be a 2-entry FIFO, first in first out.
REQ-025 A simultaneous push and pop SHALL leave the count unchanged.
REQ-026 Operand capture for the next operation SHALL proceed while earlier results wait in the buffer.

Reset
REQ-027 While RST_N is low at an edge, the block SHALL clear: state to COLLECT, all captured flags, operand registers, and the buffer (count 0).
REQ-028 After that reset edge, y_rdy=0, y_data=0 and y_carry=0; in_rdy SHALL be 0 during any cycle where RST_N is low, and all-ones in the first cycle after reset.
REQ-029 A reset in mid-operation SHALL discard partial operands and buffered results without emitting any output.

Structure
REQ-030 Package ifc_pkg SHALL hold op_t (OP_OR, OP_AND, OP_XOR, OP_ADD) and the FSM state_t.
REQ-031 The block SHALL instantiate one sub-module, ifc_result_fifo: 2 entries, WIDTH+1 bits wide, with push, pop, full and empty.

Verification
REQ-032 The bench SHALL cover these scenarios, with WIDTH=8, NUM_IN=2:
- op=OR, ch0=0x0F, ch1=0xF0 -> y_data=0xFF, y_carry=0, y_rdy high 1 cycle after the second capture.
- op=ADD, 0xFF + 0x02 -> y_data=0x01, y_carry=1.
- ch1 captured before ch0 (op=AND, 0xAA, 0x0F) -> y_data=0x0A; in_rdy[1]=0 until the push.
- 3 operations with y_en held low -> 2 buffered results; FSM stalls in COMPUTE with in_rdy=0; one pop -> third result pushed at the same edge.
- RST_N low after ch0 captured and one result buffered -> y_rdy=0 and in_rdy=2'b11 after the first edge with RST_N high; no stale output.
- NUM_IN=3, op=XOR, 0x01, 0x02, 0x04 all captured in the same cycle -> y_data=0x07.
